// File: rtl/sft_seq.sv
// Wishbone-master sequencer for the 74HC595 shift-register port: shifts a 1..4 byte frame,
// polls the done bit after each command, then latches the frame and sets output-enable.
`timescale 1ns/1ps
module sft_seq #(
    parameter logic [5:0]  ADR_SFT  = 6'h10,
    parameter logic [15:0] POLL_MAX = 16'd1000
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        START,
    input  logic [31:0] DATA,
    input  logic [2:0]  NBYTES,
    input  logic        OE_EN,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        M_CYC_O,
    output logic        M_STB_O,
    output logic        M_WE_O,
    output logic [5:0]  M_ADR_O,
    output logic [31:0] M_DAT_O,
    output logic [3:0]  M_SEL_O,
    input  logic        M_ACK_I,
    input  logic [31:0] M_DAT_I
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR_SH = 3'd1,
        S_PL_SH = 3'd2,
        S_WR_ST = 3'd3,
        S_PL_ST = 3'd4,
        S_WR_OE = 3'd5,
        S_FIN   = 3'd6,
        S_ABORT = 3'd7
    } state_t;

    // SFT register write word: data byte, inverted output-enable and command code
    function automatic logic [31:0] sft_word(input logic [7:0] din, input logic oen,
                                             input logic [1:0] cmd);
        return {16'h0000, din, 5'b00000, oen, cmd};
    endfunction

    state_t      state_r, state_s;
    logic        stb_r, stb_s;
    logic        we_r, we_s;
    logic [31:0] dat_r, dat_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        err_r, err_s;
    logic [31:0] data_r;
    logic [1:0]  idx_r;
    logic        oe_en_r;
    logic [15:0] poll_cnt_r;

    logic        accept_s;
    logic        ack_s;
    logic        sft_done_s;
    logic [2:0]  nb_s;
    logic [2:0]  nb_m1_s;
    logic [15:0] poll_inc_s;
    logic        poll_expired_s;
    logic [7:0]  byte_s;
    logic        bus_s;
    logic        wr_s;
    logic [31:0] word_s;
    logic        unused_s;

    assign accept_s       = (state_r == S_IDLE) && START;
    assign ack_s          = stb_r && M_ACK_I;
    assign sft_done_s     = M_DAT_I[3];
    assign nb_s           = (NBYTES > 3'd4) ? 3'd4 : NBYTES;
    assign nb_m1_s        = nb_s - 3'd1;
    assign poll_inc_s     = (poll_cnt_r == 16'hFFFF) ? poll_cnt_r : poll_cnt_r + 16'd1;
    assign poll_expired_s = (poll_inc_s >= POLL_MAX);
    assign byte_s         = data_r[{idx_r, 3'b000} +: 8];
    assign unused_s       = ^{M_DAT_I[31:4], M_DAT_I[2:0], nb_m1_s[2]};

    assign BUSY    = busy_r;
    assign DONE    = done_r;
    assign ERR     = err_r;
    assign M_CYC_O = stb_r;
    assign M_STB_O = stb_r;
    assign M_WE_O  = we_r;
    assign M_DAT_O = dat_r;
    assign M_ADR_O = ADR_SFT;
    assign M_SEL_O = 4'hF;

    // State register
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_s = (nb_s == 3'd0) ? S_WR_ST : S_WR_SH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WR_SH: state_s = ack_s ? S_PL_SH : S_WR_SH;
            S_PL_SH: begin
                if (!ack_s) begin
                    state_s = S_PL_SH;
                end else if (sft_done_s) begin
                    state_s = (idx_r == 2'd0) ? S_WR_ST : S_WR_SH;
                end else if (poll_expired_s) begin
                    state_s = S_ABORT;
                end else begin
                    state_s = S_PL_SH;
                end
            end
            S_WR_ST: state_s = ack_s ? S_PL_ST : S_WR_ST;
            S_PL_ST: begin
                if (!ack_s) begin
                    state_s = S_PL_ST;
                end else if (sft_done_s) begin
                    state_s = S_WR_OE;
                end else if (poll_expired_s) begin
                    state_s = S_ABORT;
                end else begin
                    state_s = S_PL_ST;
                end
            end
            S_WR_OE: state_s = ack_s ? S_FIN : S_WR_OE;
            S_FIN:   state_s = S_IDLE;
            S_ABORT: state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered bus and status outputs
    always_comb begin
        bus_s  = 1'b0;
        wr_s   = 1'b0;
        word_s = 32'h0000_0000;
        case (state_r)
            S_WR_SH: begin
                bus_s  = 1'b1;
                wr_s   = 1'b1;
                word_s = sft_word(byte_s, 1'b0, 2'b01);
            end
            S_WR_ST: begin
                bus_s  = 1'b1;
                wr_s   = 1'b1;
                word_s = sft_word(8'h00, 1'b0, 2'b10);
            end
            S_WR_OE: begin
                bus_s  = 1'b1;
                wr_s   = 1'b1;
                word_s = sft_word(8'h00, ~oe_en_r, 2'b11);
            end
            S_PL_SH, S_PL_ST: begin
                bus_s  = 1'b1;
                wr_s   = 1'b0;
                word_s = 32'h0000_0000;
            end
            default: begin
                bus_s  = 1'b0;
                wr_s   = 1'b0;
                word_s = 32'h0000_0000;
            end
        endcase

        // A new request starts only after a cycle with STB low, giving the required idle gap
        if (bus_s && !stb_r) begin
            stb_s = 1'b1;
            we_s  = wr_s;
            dat_s = word_s;
        end else if (bus_s && !ack_s) begin
            stb_s = 1'b1;
            we_s  = we_r;
            dat_s = dat_r;
        end else begin
            stb_s = 1'b0;
            we_s  = 1'b0;
            dat_s = dat_r;
        end

        busy_s = (state_s != S_IDLE);
        done_s = (state_s == S_FIN);
        if (state_s == S_ABORT) begin
            err_s = 1'b1;
        end else if (accept_s) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end
    end

    // Output registers
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            stb_r  <= 1'b0;
            we_r   <= 1'b0;
            dat_r  <= 32'h0000_0000;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            stb_r  <= stb_s;
            we_r   <= we_s;
            dat_r  <= dat_s;
            busy_r <= busy_s;
            done_r <= done_s;
            err_r  <= err_s;
        end
    end

    // Frame capture, byte index and poll counter
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            data_r     <= 32'h0000_0000;
            idx_r      <= 2'd0;
            oe_en_r    <= 1'b0;
            poll_cnt_r <= 16'd0;
        end else if (accept_s) begin
            data_r     <= DATA;
            idx_r      <= nb_m1_s[1:0];
            oe_en_r    <= OE_EN;
            poll_cnt_r <= 16'd0;
        end else if (ack_s && ((state_r == S_PL_SH) || (state_r == S_PL_ST))) begin
            if (sft_done_s) begin
                poll_cnt_r <= 16'd0;
                if ((state_r == S_PL_SH) && (idx_r != 2'd0)) begin
                    idx_r <= idx_r - 2'd1;
                end
            end else begin
                poll_cnt_r <= poll_inc_s;
            end
        end
    end

endmodule

// File: tb/tb_sft_seq.sv
// Directed bench for sft_seq: a Wishbone slave model logs writes and answers polls;
// a second instance with POLL_MAX=3 exercises the timeout path.
`timescale 1ns/1ps
module tb_sft_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] data = 32'h0;
    logic [2:0]  nbytes = 3'd0;
    logic        oe_en = 1'b0;
    logic        sel = 1'b0;

    logic        busy_a, done_a, err_a, cyc_a, stb_a, we_a;
    logic [5:0]  adr_a;
    logic [31:0] wdat_a;
    logic [3:0]  bsel_a;
    logic        busy_b, done_b, err_b, cyc_b, stb_b, we_b;
    logic [5:0]  adr_b;
    logic [31:0] wdat_b;
    logic [3:0]  bsel_b;

    logic        busy, done, err, cyc, stb, we;
    logic [5:0]  adr;
    logic [31:0] wdat;
    logic [3:0]  bsel;
    logic        s_ack;
    logic [31:0] s_rdata;

    int          cfg_polls = 0;
    logic        cfg_never = 1'b0;
    int          pend;
    logic [31:0] wr_log [0:63];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    int          bad_bus = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sft_seq #(.ADR_SFT(6'h12), .POLL_MAX(16'd1000)) dut (
        .CLK_I(clk), .RST_I(rst), .START(start & ~sel), .DATA(data), .NBYTES(nbytes),
        .OE_EN(oe_en), .BUSY(busy_a), .DONE(done_a), .ERR(err_a), .M_CYC_O(cyc_a),
        .M_STB_O(stb_a), .M_WE_O(we_a), .M_ADR_O(adr_a), .M_DAT_O(wdat_a), .M_SEL_O(bsel_a),
        .M_ACK_I(s_ack & ~sel), .M_DAT_I(s_rdata)
    );

    sft_seq #(.ADR_SFT(6'h12), .POLL_MAX(16'd3)) dut_p3 (
        .CLK_I(clk), .RST_I(rst), .START(start & sel), .DATA(data), .NBYTES(nbytes),
        .OE_EN(oe_en), .BUSY(busy_b), .DONE(done_b), .ERR(err_b), .M_CYC_O(cyc_b),
        .M_STB_O(stb_b), .M_WE_O(we_b), .M_ADR_O(adr_b), .M_DAT_O(wdat_b), .M_SEL_O(bsel_b),
        .M_ACK_I(s_ack & sel), .M_DAT_I(s_rdata)
    );

    assign busy = sel ? busy_b : busy_a;
    assign done = sel ? done_b : done_a;
    assign err  = sel ? err_b  : err_a;
    assign cyc  = sel ? cyc_b  : cyc_a;
    assign stb  = sel ? stb_b  : stb_a;
    assign we   = sel ? we_b   : we_a;
    assign adr  = sel ? adr_b  : adr_a;
    assign wdat = sel ? wdat_b : wdat_a;
    assign bsel = sel ? bsel_b : bsel_a;

    // Slave: acks one cycle after STB; done bit cleared by each write, set after cfg_polls reads
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ack   <= 1'b0;
            s_rdata <= 32'h0;
            pend    <= 0;
        end else if (cyc && stb && !s_ack) begin
            s_ack <= 1'b1;
            if (adr !== 6'h12 || bsel !== 4'hF) bad_bus <= bad_bus + 1;
            if (we) begin
                wr_log[6'(wr_cnt)] <= wdat;
                wr_cnt <= wr_cnt + 1;
                pend   <= cfg_polls;
            end else begin
                rd_cnt <= rd_cnt + 1;
                if (cfg_never || pend != 0) begin
                    s_rdata <= 32'h0000_0000;
                    if (pend != 0) pend <= pend - 1;
                end else begin
                    s_rdata <= 32'h0000_0008;
                end
            end
        end else begin
            s_ack <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic pulse_start(input logic [31:0] d, input logic [2:0] n, input logic o);
        @(negedge clk);
        data = d; nbytes = n; oe_en = o; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_timeout busy=%0b required 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_a, done_a, err_a, cyc_a, stb_a, we_a} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b required 000000", {busy_a, done_a, err_a, cyc_a, stb_a, we_a});
        end
        checks++;
        if (wdat_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_dat got %h required 00000000", wdat_a);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err, cyc, stb} !== 5'b0) begin
            errors++;
            $display("FAIL post_reset_idle got %b required 00000", {busy, done, err, cyc, stb});
        end
    endtask

    task automatic test_shift_two();
        logic [31:0] exp_w [4];
        int wb = wr_cnt, rb = rd_cnt, db = done_cnt;
        exp_w = '{32'h0000A501, 32'h00005A01, 32'h00000002, 32'h00000003};
        sel = 1'b0; cfg_polls = 0; cfg_never = 1'b0;
        pulse_start(32'h0000_A55A, 3'd2, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL shift2_busy got %b required 1", busy);
        end
        wait_idle("shift2");
        checks++;
        if (wr_cnt - wb !== 4) begin
            errors++;
            $display("FAIL shift2_nwrites got %0d required 4", wr_cnt - wb);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_log[6'(wb + i)] !== exp_w[i]) begin
                errors++;
                $display("FAIL shift2_word%0d got %h required %h", i, wr_log[6'(wb + i)], exp_w[i]);
            end
        end
        checks++;
        if (rd_cnt - rb !== 3) begin
            errors++;
            $display("FAIL shift2_nreads got %0d required 3", rd_cnt - rb);
        end
        checks++;
        if (done_cnt - db !== 1 || err !== 1'b0) begin
            errors++;
            $display("FAIL shift2_done_err got done=%0d err=%b required done=1 err=0", done_cnt - db, err);
        end
    endtask

    task automatic test_latch_only();
        int wb = wr_cnt, rb = rd_cnt, db = done_cnt;
        pulse_start(32'hFFFF_FFFF, 3'd0, 1'b0);
        wait_idle("latch");
        checks++;
        if (wr_cnt - wb !== 2 || wr_log[6'(wb)] !== 32'h2 || wr_log[6'(wb + 1)] !== 32'h7) begin
            errors++;
            $display("FAIL latch_writes got n=%0d %h %h required n=2 00000002 00000007",
                     wr_cnt - wb, wr_log[6'(wb)], wr_log[6'(wb + 1)]);
        end
        checks++;
        if (rd_cnt - rb !== 1 || done_cnt - db !== 1) begin
            errors++;
            $display("FAIL latch_rd_done got rd=%0d done=%0d required rd=1 done=1", rd_cnt - rb, done_cnt - db);
        end
    endtask

    task automatic test_slow_poll();
        int wb = wr_cnt, rb = rd_cnt, db = done_cnt;
        cfg_polls = 5;
        pulse_start(32'h0, 3'd0, 1'b1);
        wait_idle("slowpoll");
        cfg_polls = 0;
        checks++;
        if (rd_cnt - rb !== 6) begin
            errors++;
            $display("FAIL slowpoll_nreads got %0d required 6", rd_cnt - rb);
        end
        checks++;
        if (wr_cnt - wb !== 2 || wr_log[6'(wb + 1)] !== 32'h3 || done_cnt - db !== 1 || err !== 1'b0) begin
            errors++;
            $display("FAIL slowpoll_result got n=%0d last=%h done=%0d err=%b required n=2 last=00000003 done=1 err=0",
                     wr_cnt - wb, wr_log[6'(wb + 1)], done_cnt - db, err);
        end
    endtask

    task automatic test_timeout();
        int wb = wr_cnt, rb = rd_cnt, db = done_cnt;
        sel = 1'b1; cfg_never = 1'b1;
        pulse_start(32'h0000_00C3, 3'd1, 1'b1);
        wait_idle("timeout");
        cfg_never = 1'b0;
        checks++;
        if (err !== 1'b1 || done_cnt - db !== 0) begin
            errors++;
            $display("FAIL timeout_err got err=%b done=%0d required err=1 done=0", err, done_cnt - db);
        end
        checks++;
        if (wr_cnt - wb !== 1 || wr_log[6'(wb)] !== 32'h0000C301) begin
            errors++;
            $display("FAIL timeout_writes got n=%0d first=%h required n=1 first=0000C301", wr_cnt - wb, wr_log[6'(wb)]);
        end
        checks++;
        if (rd_cnt - rb !== 3) begin
            errors++;
            $display("FAIL timeout_nreads got %0d required 3", rd_cnt - rb);
        end
        db = done_cnt;
        pulse_start(32'h0, 3'd0, 1'b1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_errclear got %b required 0", err);
        end
        wait_idle("timeout_retry");
        checks++;
        if (done_cnt - db !== 1 || err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_retry got done=%0d err=%b required done=1 err=0", done_cnt - db, err);
        end
        sel = 1'b0;
    endtask

    task automatic test_busy_ignore();
        logic [31:0] exp_w [6];
        int wb = wr_cnt, db = done_cnt;
        exp_w = '{32'h1101, 32'h2201, 32'h3301, 32'h4401, 32'h2, 32'h3};
        pulse_start(32'h1122_3344, 3'd7, 1'b1);
        repeat (3) @(negedge clk);
        pulse_start(32'hDEAD_BEEF, 3'd1, 1'b0);
        wait_idle("busyign");
        repeat (10) @(negedge clk);
        checks++;
        if (wr_cnt - wb !== 6) begin
            errors++;
            $display("FAIL busyign_nwrites got %0d required 6", wr_cnt - wb);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (wr_log[6'(wb + i)] !== exp_w[i]) begin
                errors++;
                $display("FAIL busyign_word%0d got %h required %h", i, wr_log[6'(wb + i)], exp_w[i]);
            end
        end
        checks++;
        if (done_cnt - db !== 1) begin
            errors++;
            $display("FAIL busyign_done got %0d required 1", done_cnt - db);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int wb, db;
        pulse_start(32'h0000_00AA, 3'd1, 1'b1);
        while (!(stb && we) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(stb && we)) begin
            errors++;
            $display("FAIL rstmid_no_write_strobe got stb=%b we=%b required 1 1", stb, we);
        end
        db = done_cnt;
        rst = 1'b1;
        #1;
        checks++;
        if ({cyc, stb, busy, done} !== 4'b0) begin
            errors++;
            $display("FAIL rstmid_drop got %b required 0000", {cyc, stb, busy, done});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt - db !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet got done=%0d busy=%b required 0 0", done_cnt - db, busy);
        end
        wb = wr_cnt; db = done_cnt;
        pulse_start(32'h0000_0055, 3'd1, 1'b1);
        wait_idle("rstmid_after");
        checks++;
        if (wr_cnt - wb !== 3 || wr_log[6'(wb)] !== 32'h5501 || wr_log[6'(wb + 2)] !== 32'h3 || done_cnt - db !== 1) begin
            errors++;
            $display("FAIL rstmid_after got n=%0d w0=%h w2=%h done=%0d required n=3 w0=00005501 w2=00000003 done=1",
                     wr_cnt - wb, wr_log[6'(wb)], wr_log[6'(wb + 2)], done_cnt - db);
        end
    endtask

    initial begin
        test_reset();
        test_shift_two();
        test_latch_only();
        test_slow_poll();
        test_timeout();
        test_busy_ignore();
        test_reset_mid();
        checks++;
        if (bad_bus !== 0) begin
            errors++;
            $display("FAIL bus_adr_sel got %0d bad requests required 0", bad_bus);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
